// File: rtl/banco_registros_mp_if.sv
// -----------------------------------------------------------------------------
// banco_registros_mp_if
//
// Bus bundle for the multi-port register bank.
//
// Signals (master = user of the bank, slave = the bank):
//   clr         master->slave  1      single-cycle request to zero the array
//   busy        slave->master  1      clear engine running, reads forced to 0
//   wr_en       master->slave  1      write strobe
//   wr_mask     master->slave  NL     per-lane write enable, bit i = lane i
//   address_w   master->slave  A      write address
//   data_in     master->slave  W      write data
//   address_r   master->slave  NR*A   packed read addresses, port k at [k*A +: A]
//   data_out    slave->master  NR*W   packed read data, port k at [k*W +: W]
//   data_out_w  slave->master  W      contents at address_w
//
// Handshake: there is no ready. wr_en is a one-way strobe that the bank
// accepts on a rising edge only when busy=0, clr=0 and reset is not asserted;
// in every other cycle it is dropped silently. busy is the only indication the
// master gets that writes are being ignored. Reads never stall.
// -----------------------------------------------------------------------------
interface banco_registros_mp_if #(
    parameter int W  = 8,
    parameter int A  = 4,
    parameter int NR = 2,
    parameter int L  = 8
);
    localparam int NL = W / L;

    logic              clr;
    logic              busy;
    logic              wr_en;
    logic [NL-1:0]     wr_mask;
    logic [A-1:0]      address_w;
    logic [W-1:0]      data_in;
    logic [NR*A-1:0]   address_r;
    logic [NR*W-1:0]   data_out;
    logic [W-1:0]      data_out_w;

    modport master (
        output clr,
        output wr_en,
        output wr_mask,
        output address_w,
        output data_in,
        output address_r,
        input  busy,
        input  data_out,
        input  data_out_w
    );

    modport slave (
        input  clr,
        input  wr_en,
        input  wr_mask,
        input  address_w,
        input  data_in,
        input  address_r,
        output busy,
        output data_out,
        output data_out_w
    );
endinterface

// File: rtl/banco_registros_mp.sv
// -----------------------------------------------------------------------------
// banco_registros_mp
//
// Multi-port register bank for FIFO/queue datapaths: one lane-masked write
// port, NR independent read ports and one extra read port that always looks at
// the write address. Reads are combinational (REG_OUT=0) or registered with a
// one-cycle latency (REG_OUT=1). With BYPASS=1 a read that hits the address
// being written in the same cycle returns the new lanes (write-first).
//
// A sequential clear engine walks the whole array writing zeros, one entry per
// cycle, after every reset and on every clr pulse. While it runs busy=1, writes
// are dropped and every read port returns 0, so the undefined power-up
// contents never reach the outputs.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   bus        banco_registros_mp_if.slave (clr, busy, write port, read ports)
//   state_dbg  current engine state: 1 = CLEAR sweep running, 0 = IDLE
// -----------------------------------------------------------------------------
module banco_registros_mp #(
    parameter int W       = 8,
    parameter int A       = 4,
    parameter int NR      = 2,
    parameter int L       = 8,
    parameter int REG_OUT = 0,
    parameter int BYPASS  = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    banco_registros_mp_if.slave    bus,
    output logic                   state_dbg
);
    localparam int NL = W / L;
    localparam int D  = 1 << A;

    // clr_cnt is one bit wider than an address so the terminal value D-1 and
    // the increment never wrap inside the counter itself.
    localparam logic [A:0] CNT_LAST = (A + 1)'(D - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [A:0]   clr_cnt_q;
    logic [A:0]   clr_cnt_d;

    logic         busy_int;
    logic         clr_we;
    logic         wr_acc;

    logic [W-1:0] mem [D];

    // -------------------------------------------------------------------------
    // Clear engine: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Clear engine: next state and control
    // A clr pulse during a sweep restarts it from entry 0, which stretches busy
    // to a full D cycles after the last clr. clr always wins over a write.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we = reset_n;
                if (bus.clr) begin
                    clr_cnt_d = '0;
                end else if (clr_cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (bus.clr) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    assign busy_int  = (state_q == ST_CLEAR);
    assign bus.busy  = busy_int;
    assign state_dbg = (state_q == ST_CLEAR);

    // A write lands only from IDLE, with no clr and no reset on the same edge.
    assign wr_acc = reset_n && !busy_int && !bus.clr && bus.wr_en;

    // -------------------------------------------------------------------------
    // Storage. No reset on the array itself: the clear engine is what zeroes it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt_q[A-1:0]] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NL; i++) begin
                if (bus.wr_mask[i]) begin
                    mem[bus.address_w][i*L +: L] <= bus.data_in[i*L +: L];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read ports. Index NR is the dedicated port at the write address; it uses
    // exactly the same forwarding, forcing and registering as the others.
    // -------------------------------------------------------------------------
    for (genvar k = 0; k <= NR; k++) begin : g_rd
        logic [A-1:0] addr;
        logic [W-1:0] rd_c;
        logic [W-1:0] rd_o;

        if (k == NR) begin : g_aw
            assign addr = bus.address_w;
        end else begin : g_ar
            assign addr = bus.address_r[k*A +: A];
        end

        // Value this port presents in the current cycle: stored word, with
        // the accepted write's enabled lanes forwarded on an address hit,
        // and forced to zero while the sweep runs.
        always_comb begin
            rd_c = mem[addr];
            if ((BYPASS != 0) && wr_acc && (addr == bus.address_w)) begin
                for (int i = 0; i < NL; i++) begin
                    if (bus.wr_mask[i]) begin
                        rd_c[i*L +: L] = bus.data_in[i*L +: L];
                    end
                end
            end
            if (busy_int) begin
                rd_c = '0;
            end
        end

        if (REG_OUT != 0) begin : g_reg
            logic [W-1:0] rd_q;
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    rd_q <= '0;
                end else begin
                    rd_q <= rd_c;
                end
            end
            assign rd_o = rd_q;
        end else begin : g_comb
            assign rd_o = rd_c;
        end

        if (k == NR) begin : g_out_w
            assign bus.data_out_w = rd_o;
        end else begin : g_out_r
            assign bus.data_out[k*W +: W] = rd_o;
        end
    end

endmodule

// File: doc/banco_registros_mp.md
Name: banco_registros_mp

Overview:
Parametrised multi-port register bank for FIFO and queue datapaths. It provides one write port with per-lane write mask and NR independent read ports, plus a dedicated read port at the write address. Read mode is selectable: combinational or registered, with optional write-first bypass. A sequential clear engine zeroes the array after reset or on request.

Parameters:
W, 8, word width in bits; must be a multiple of L
A, 4, address bits; depth D = 2**A
NR, 2, number of read ports (1..4)
L, 8, lane width for the write mask; number of lanes NL = W/L
REG_OUT, 0, 0 = combinational reads; 1 = registered reads (1-cycle latency)
BYPASS, 1, 1 = write-first forwarding on read/write address match; 0 = read-old

Ports:
clk  in  1  rising-edge clock, sole clock domain
reset_n  in  1  synchronous active-low reset, sampled on rising edge of clk
clr  in  1  single-cycle request to zero the whole array
busy  out  1  high while the clear engine runs
wr_en  in  1  write strobe
wr_mask  in  NL  per-lane enable; bit i covers data_in[i*L +: L]
address_w  in  A  write address
data_in  in  W  write data
address_r  in  NR*A  packed read addresses; port k = address_r[k*A +: A]
data_out  out  NR*W  packed read data; port k = data_out[k*W +: W]
data_out_w  out  W  contents at address_w, same timing and bypass rules as data_out

Behaviour:
- FSM states: CLEAR, IDLE. reset_n=0 at an edge -> CLEAR, clr_cnt=0, busy=1, registered outputs=0.
- CLEAR: each cycle writes array[clr_cnt] <= 0, then clr_cnt++. When clr_cnt = D-1, the state moves to IDLE on that edge. busy=0 from the next cycle. Total busy = D cycles after reset_n is released.
- IDLE: clr=1 -> CLEAR with clr_cnt=0, busy=1 on the next cycle.
- clr=1 while in CLEAR restarts clr_cnt at 0, so busy is extended.
- reset_n=0 mid-clear restarts the sweep at 0. Reset has priority over clr. clr has priority over wr_en.
- Write (IDLE, busy=0, wr_en=1, clr=0): for each lane i with wr_mask[i]=1, array[address_w] lane i <= data_in lane i. Lanes with mask 0 are unchanged. wr_mask=0 is a legal no-op.
- wr_en while busy=1 or while clr=1 is dropped silently. No error flag.
- Read while busy=1: data_out and data_out_w are forced to 0. With REG_OUT=1 this is the registered value, so 0 is seen one cycle after busy rises, and clean data one cycle after busy falls.
- REG_OUT=0: data_out_k = array[address_r_k] combinationally.
  - BYPASS=1: if a write is accepted this cycle and address_r_k = address_w, masked lanes show data_in and the other lanes show stored data.
- REG_OUT=1: data_out_k is registered at each edge from the same value the combinational path would present that cycle. Latency is 1 cycle.
  - BYPASS=1 makes same-cycle write-then-read return new data (write-first).
  - BYPASS=0 returns old data (read-first).
- All NR ports are independent. Any subset may share an address, and all of them get identical data. Reads never stall.
- No arithmetic besides clr_cnt. clr_cnt is A+1 bits so the terminal compare does not overflow at D-1.
- Array contents are undefined only before the first clear completes. Outputs are 0 during that time, so X never propagates.

Test Plan:
- Reset release, W=8, A=4: busy=1 for exactly 16 cycles, then 0. All 16 addresses read 0x00 on every port.
- Masked write, W=16, L=8: array[3]=0xABCD, then write data_in=0x1234 with wr_mask=2'b01 -> port 0 at address 3 reads 0xAB34.
- Bypass, REG_OUT=0, BYPASS=1: write 0x5A to address 7 while address_r_0=7 -> data_out_0=0x5A in the same cycle. With BYPASS=0 it shows the old 0x00 and 0x5A on the next cycle.
- Registered reads, REG_OUT=1: address_r_1 changes 2 -> 9 (array[9]=0x77) -> data_out_1=0x77 exactly one edge later. Two ports reading address 9 match.
- Clear collision: clr and wr_en on the same edge in IDLE -> write dropped, busy=1 next cycle. clr pulsed again at sweep cycle 10 -> busy lasts 16 more cycles.
- Reset mid-clear: reset_n low for 1 cycle at sweep cycle 5 -> busy persists 16 cycles after release, and all entries written before the clear read 0.
